// File: rtl/uart_rx_edge_bit_sampler.sv
// UART receiver timing front end: oversample edge counter, bit counter and
// a 3-point mid-bit majority vote of the serial line.
module uart_rx_edge_bit_sampler #(
   parameter int PRESC_W = 6,
   parameter int EDGE_W  = 5,
   parameter int BIT_W   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               dat_samp_en,
   input  logic               RX_IN,
   input  logic [PRESC_W-1:0] Prescale,
   output logic [EDGE_W-1:0]  edge_cnt,
   output logic [BIT_W-1:0]   bit_cnt,
   output logic               sampled_bit,
   output logic               samp_valid,
   output logic               bit_tick
);

   localparam logic [BIT_W-1:0] BIT_MAX = {BIT_W{1'b1}};

   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [EDGE_W-1:0]  edge_q, edge_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic               s0_q, s0_d, s1_q, s1_d;
   logic               samp_q, samp_d;
   logic               valid_q, valid_d;
   logic               tick_q, tick_d;

   logic [PRESC_W-1:0] edge_ext, half;
   logic               presc_legal, wrap, vote_en;

   assign edge_ext    = PRESC_W'(edge_q);
   assign half        = presc_q >> 1;
   assign wrap        = (edge_ext == presc_q - PRESC_W'(1));
   assign vote_en     = enable & dat_samp_en;
   assign presc_legal = (Prescale == PRESC_W'(8)) || (Prescale == PRESC_W'(16)) ||
                        (Prescale == PRESC_W'(32));

   always_comb begin
      presc_d = presc_q;
      edge_d  = edge_q;
      bit_d   = bit_q;
      s0_d    = s0_q;
      s1_d    = s1_q;
      samp_d  = samp_q;
      valid_d = 1'b0;
      tick_d  = 1'b0;

      if (!enable) begin
         // ratio tracks the input only while idle so a frame runs at one rate
         presc_d = presc_legal ? Prescale : PRESC_W'(8);
         edge_d  = '0;
         bit_d   = '0;
      end else if (wrap) begin
         edge_d = '0;
         tick_d = 1'b1;
         if (bit_q != BIT_MAX) bit_d = bit_q + BIT_W'(1);
      end else begin
         edge_d = edge_q + EDGE_W'(1);
      end

      if (vote_en) begin
         if (edge_ext == half - PRESC_W'(2)) s0_d = RX_IN;
         if (edge_ext == half - PRESC_W'(1)) s1_d = RX_IN;
         if (edge_ext == half) begin
            samp_d  = (s0_q & s1_q) | (s0_q & RX_IN) | (s1_q & RX_IN);
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= PRESC_W'(8);
         edge_q  <= '0;
         bit_q   <= '0;
         s0_q    <= 1'b1;
         s1_q    <= 1'b1;
         samp_q  <= 1'b1;
         valid_q <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         edge_q  <= edge_d;
         bit_q   <= bit_d;
         s0_q    <= s0_d;
         s1_q    <= s1_d;
         samp_q  <= samp_d;
         valid_q <= valid_d;
         tick_q  <= tick_d;
      end
   end

   assign edge_cnt    = edge_q;
   assign bit_cnt     = bit_q;
   assign sampled_bit = samp_q;
   assign samp_valid  = valid_q;
   assign bit_tick    = tick_q;

endmodule
